cache_control: RTL

Controller for the 8-set, direct-mapped, 128-bit-line LC-3b cache. Sits between the CPU memory port and physical memory, owns the tag/valid/dirty state, and drives the data array's set select, write strobe and write data. Performs write-back of dirty victims and line fills on misses. Write-allocate policy.

---
 rtl/cache_control_if.sv | 43 ++++
 rtl/cache_control.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cache_control_if.sv
// Bus bundle for the LC-3b cache controller: CPU request port, physical
// memory port and the data-array control port, grouped in one interface.
// "slave" is the controller's view; "master" is the surrounding system.
interface cache_control_if;
  // CPU side
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  // Physical memory side
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  // Data array side
  logic [2:0]   data_set;
  logic         data_write;
  logic [127:0] data_in;
  logic [127:0] data_out;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output data_set, data_write, data_in,
    input  data_out
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  data_set, data_write, data_in,
    output data_out
  );
endinterface

// File: rtl/cache_control.sv
// Direct-mapped, 8-set, 128-bit-line cache controller with write-back and
// write-allocate. Owns tag/valid/dirty state; the line storage itself lives
// in an external data array addressed by data_set.
module cache_control (
  input  logic           clk,
  input  logic           reset,
  cache_control_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } state_t;

  state_t       r_state;
  logic [8:0]   r_tag [8];
  logic [7:0]   r_valid;
  logic [7:0]   r_dirty;
  logic         r_pmem_read;
  logic         r_pmem_write;

  logic [2:0]   w_index;
  logic [8:0]   w_addr_tag;
  logic [2:0]   w_offset;
  logic         w_hit;
  logic         w_req;
  logic         w_wr;
  logic         w_unused_byte;

  // Select one 16-bit word out of a line.
  function automatic logic [15:0] sel_word(input logic [127:0] line,
                                           input logic [2:0]   off);
    return line[{off, 4'b0000} +: 16];
  endfunction

  // Replace the enabled byte lanes of one word inside a line.
  function automatic logic [127:0] merge_line(input logic [127:0] line,
                                              input logic [2:0]   off,
                                              input logic [1:0]   be,
                                              input logic [15:0]  wd);
    logic [127:0] res;
    res = line;
    if (be[0]) res[{off, 4'b0000} +: 8] = wd[7:0];
    if (be[1]) res[{off, 4'b1000} +: 8] = wd[15:8];
    return res;
  endfunction

  assign w_index       = bus.mem_address[6:4];
  assign w_addr_tag    = bus.mem_address[15:7];
  assign w_offset      = bus.mem_address[3:1];
  assign w_unused_byte = bus.mem_address[0];
  assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_addr_tag);
  assign w_req         = bus.mem_read | bus.mem_write;
  // A simultaneous read+write is handled as a write.
  assign w_wr          = bus.mem_write;

  assign bus.data_set   = w_index;
  assign bus.mem_rdata  = sel_word(bus.data_out, w_offset);
  assign bus.pmem_wdata = bus.data_out;
  assign bus.pmem_read  = r_pmem_read;
  assign bus.pmem_write = r_pmem_write;

  // Hit response, data-array write strobe/data and physical address per state.
  always_comb begin
    bus.mem_resp     = 1'b0;
    bus.data_write   = 1'b0;
    bus.data_in      = bus.pmem_rdata;
    bus.pmem_address = {bus.mem_address[15:4], 4'b0000};
    case (r_state)
      S_IDLE: begin
        if (w_req && w_hit) begin
          bus.mem_resp = 1'b1;
          if (w_wr) begin
            bus.data_write = 1'b1;
            bus.data_in    = merge_line(bus.data_out, w_offset,
                                        bus.mem_byte_enable, bus.mem_wdata);
          end
        end
      end
      S_WRITEBACK: begin
        bus.pmem_address = {r_tag[w_index], w_index, 4'b0000};
      end
      S_FILL: begin
        if (bus.pmem_resp) bus.data_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Miss-handling FSM with registered pmem strobes and valid/dirty tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              if (w_wr) r_dirty[w_index] <= 1'b1;
            end else if (r_valid[w_index] && r_dirty[w_index]) begin
              r_state      <= S_WRITEBACK;
              r_pmem_write <= 1'b1;
            end else begin
              r_state     <= S_FILL;
              r_pmem_read <= 1'b1;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.pmem_resp) begin
            r_state      <= S_FILL;
            r_pmem_write <= 1'b0;
            r_pmem_read  <= 1'b1;
          end
        end
        S_FILL: begin
          if (bus.pmem_resp) begin
            r_state          <= S_IDLE;
            r_pmem_read      <= 1'b0;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

  // Tag array: written on fill completion; contents are masked by valid.
  always_ff @(posedge clk) begin
    if (r_state == S_FILL && bus.pmem_resp) r_tag[w_index] <= w_addr_tag;
  end

endmodule
